nibble_add: RTL and testbench
=============================

Name: nibble_add

Overview:
- Registered 4-bit nibble adder.
- Selects one nibble of each 8-bit operand and adds the two nibbles; the result is a 5-bit sum with carry.
  - ctrl=0: lower nibbles are added.
  - ctrl=1: upper nibbles are added.
- Small datapath leaf used wherever per-nibble arithmetic on byte-wide buses is needed.
- Single clock domain. Output is registered with a valid flag.

Parameters:
- None. Widths are fixed: 8-bit operands, 4-bit nibbles, 5-bit result.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  8  operand A
- b  input  8  operand B
- ctrl  input  1  nibble select: 0 = a[3:0]+b[3:0], 1 = a[7:4]+b[7:4]
- in_valid  input  1  operands/ctrl valid this cycle
- q  output  5  registered sum; q[4] = carry out, q[3:0] = sum nibble
- out_valid  output  1  q updated on the previous clock edge
- Positional port order is clk, rst_n, a, b, ctrl, in_valid, q, out_valid.

Behaviour:
- Reset is asynchronous and active-low.
  - rst_n=0 immediately forces q=5'b0 and out_valid=0, regardless of clk.
  - Release is sampled on the next rising clk edge.
- Nibble select is combinational on the current inputs:
  - na = ctrl ? a[7:4] : a[3:0]
  - nb = ctrl ? b[7:4] : b[3:0]
- Sum is an unsigned zero-extended 5-bit add: sum = {1'b0,na} + {1'b0,nb}.
  - Range 0..30; never overflows 5 bits.
  - Carry is not fed in from any other nibble and there is no carry-in.
  - The unselected nibbles have no effect on q.
- Datapath: 4-bit ripple-carry chain of full adders. The final carry drives sum[4].
- Latency is 1 cycle.
  - On a rising edge with in_valid=1: q <= sum and out_valid <= 1.
  - On a rising edge with in_valid=0: q holds its previous value and out_valid <= 0.
- Back-to-back in_valid=1 gives one result per cycle. No stall and no backpressure.
- ctrl may change every cycle. Only the value sampled with in_valid=1 matters.
- Reset mid-stream discards any pending result. The first valid cycle after release behaves like any other.
- X on a, b or ctrl while in_valid=0 must not propagate into q.

Optional Feature:
- Macro: NIBBLE_ADD_PIPE_EN.
- Defined: a second register stage is inserted after the adder.
  - Latency becomes 2 cycles.
  - out_valid is delayed identically to q.
  - Both stages are reset asynchronously to 0.
- Not defined: single-stage, 1-cycle latency as specified above.
- Functional results are identical in both builds; only latency differs.

Test Plan:
- Lower-nibble add (ctrl=0): apply each input with in_valid=1 and check q one cycle later, out_valid=1.
  - a=8'h24, b=8'h81 -> q=5'd5
  - a=8'h09, b=8'h63 -> q=5'd12
  - a=8'h0D, b=8'h8D -> q=5'd26, q[4]=1
- Upper-nibble add (ctrl=1):
  - a=8'h76, b=8'h3D -> q=5'd10
  - a=8'hF9, b=8'hC6 -> q=5'd27
  - a=8'hF2, b=8'hCE -> q=5'd27
  - a=8'h12, b=8'h8F -> q=5'd9
- Boundary values:
  - ctrl=0, a=8'h0F, b=8'h0F -> q=5'd30
  - ctrl=1, a=8'h0F, b=8'h0F -> q=5'd0 (unselected nibbles ignored)
- Hold behaviour: load q=5'd10, then drive in_valid=0 with random a/b/ctrl for 3 cycles -> q stays 5'd10 and out_valid=0.
- Asynchronous reset: with q=5'd27, pulse rst_n=0 between clock edges -> q=0 and out_valid=0 immediately. After release, ctrl=0, a=8'h01, b=8'h0D -> q=5'd14.
- Pipelined build (NIBBLE_ADD_PIPE_EN defined): stream the eight vectors above back-to-back -> same q sequence delayed 2 cycles, with out_valid aligned to q.

Source files
------------

// File: rtl/nibble_add.sv
// nibble_add: registered 4-bit nibble adder.
//
// This block picks one nibble from each 8-bit operand and adds the two nibbles.
// The result is a 5-bit sum, with the carry out in the top bit.
//   ctrl = 0 : a[3:0] + b[3:0]
//   ctrl = 1 : a[7:4] + b[7:4]
// There is no carry-in, and the unselected nibbles have no effect.
//
// The adder is a 4-bit ripple-carry chain. The output is registered with a valid flag.
//
// Build option:
//   NIBBLE_ADD_PIPE_EN  When defined, a second register stage follows the adder.
//                       Latency is then 2 cycles instead of 1, and out_valid is delayed
//                       exactly like q.
//
// Ports:
//   clk       in   1  system clock, rising-edge active
//   rst_n     in   1  asynchronous active-low reset
//   a         in   8  operand A
//   b         in   8  operand B
//   ctrl      in   1  nibble select (0 = low, 1 = high)
//   in_valid  in   1  a/b/ctrl valid this cycle
//   q         out  5  registered sum, q[4] = carry out
//   out_valid out  1  q was updated by the previous clock edge
module nibble_add (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ctrl,
  input  logic       in_valid,
  output logic [4:0] q,
  output logic       out_valid
);

  logic [3:0] na;
  logic [3:0] nb;
  logic [4:0] carry;
  logic [4:0] sum;

  // Nibble select and ripple-carry add
  always_comb begin
    na       = ctrl ? a[7:4] : a[3:0];
    nb       = ctrl ? b[7:4] : b[3:0];
    carry    = '0;
    sum      = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sum[i]     = na[i] ^ nb[i] ^ carry[i];
      carry[i+1] = (na[i] & nb[i]) | (carry[i] & (na[i] ^ nb[i]));
    end
    sum[4] = carry[4];
  end

  // Stage 1: result register
  logic [4:0] s1_q, s1_d;
  logic       v1_q, v1_d;

  // The datapath only loads when in_valid is set, so X on the inputs during idle
  // cycles never reaches the register.
  always_comb begin
    s1_d = s1_q;
    v1_d = in_valid;
    if (in_valid) begin
      s1_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      v1_q <= v1_d;
    end
  end

`ifdef NIBBLE_ADD_PIPE_EN
  // Stage 2: extra register that delays q and out_valid together
  logic [4:0] s2_q, s2_d;
  logic       v2_q, v2_d;

  always_comb begin
    s2_d = s2_q;
    v2_d = v1_q;
    if (v1_q) begin
      s2_d = s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q <= '0;
      v2_q <= 1'b0;
    end else begin
      s2_q <= s2_d;
      v2_q <= v2_d;
    end
  end

  assign q         = s2_q;
  assign out_valid = v2_q;
`else
  assign q         = s1_q;
  assign out_valid = v1_q;
`endif

endmodule

// File: tb/tb_nibble_add.sv
// tb_nibble_add: directed self-checking bench for nibble_add.
// It adapts to the NIBBLE_ADD_PIPE_EN build by adjusting the expected latency.
module tb_nibble_add;

`ifdef NIBBLE_ADD_PIPE_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 1;
`endif
  localparam int unsigned NumVec = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       ctrl;
  logic       in_valid;
  logic [4:0] q;
  logic       out_valid;

  int n_checks;
  int n_errors;

  nibble_add u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .ctrl     (ctrl),
    .in_valid (in_valid),
    .q        (q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: fail loudly instead of hanging.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one vector, let it reach the output, then check q and out_valid.
  task automatic apply(input string tag, input logic c, input logic [7:0] va,
                       input logic [7:0] vb, input logic [4:0] exp);
    @(negedge clk);
    ctrl     = c;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i < int'(Lat); i++) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_q"}, 32'(q), 32'(exp));
    check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  logic       vec_c [NumVec];
  logic [7:0] vec_a [NumVec];
  logic [7:0] vec_b [NumVec];
  logic [4:0] vec_q [NumVec];

  initial begin
    vec_c[0] = 1'b0; vec_a[0] = 8'h24; vec_b[0] = 8'h81; vec_q[0] = 5'd5;
    vec_c[1] = 1'b0; vec_a[1] = 8'h09; vec_b[1] = 8'h63; vec_q[1] = 5'd12;
    vec_c[2] = 1'b0; vec_a[2] = 8'h0D; vec_b[2] = 8'h8D; vec_q[2] = 5'd26;
    vec_c[3] = 1'b1; vec_a[3] = 8'h76; vec_b[3] = 8'h3D; vec_q[3] = 5'd10;
    vec_c[4] = 1'b1; vec_a[4] = 8'hF9; vec_b[4] = 8'hC6; vec_q[4] = 5'd27;
    vec_c[5] = 1'b1; vec_a[5] = 8'hF2; vec_b[5] = 8'hCE; vec_q[5] = 5'd27;
    vec_c[6] = 1'b1; vec_a[6] = 8'h12; vec_b[6] = 8'h8F; vec_q[6] = 5'd9;
    vec_c[7] = 1'b0; vec_a[7] = 8'h0F; vec_b[7] = 8'h0F; vec_q[7] = 5'd30;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    ctrl     = 1'b0;
    in_valid = 1'b0;

    // Reset state, checked before any clock edge
    #2;
    check_eq("rst_q", 32'(q), 32'd0);
    check_eq("rst_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    apply("lo_05", 1'b0, 8'h24, 8'h81, 5'd5);
    apply("lo_12", 1'b0, 8'h09, 8'h63, 5'd12);
    apply("lo_26", 1'b0, 8'h0D, 8'h8D, 5'd26);
    check_eq("lo_26_carry", 32'(q[4]), 32'd1);
    apply("hi_10", 1'b1, 8'h76, 8'h3D, 5'd10);
    apply("hi_27a", 1'b1, 8'hF9, 8'hC6, 5'd27);
    apply("hi_27b", 1'b1, 8'hF2, 8'hCE, 5'd27);
    apply("hi_09", 1'b1, 8'h12, 8'h8F, 5'd9);
    apply("bnd_30", 1'b0, 8'h0F, 8'h0F, 5'd30);
    apply("bnd_00", 1'b1, 8'h0F, 8'h0F, 5'd0);

    // Hold: q keeps its value while in_valid is low
    apply("hold_ld", 1'b1, 8'h76, 8'h3D, 5'd10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      ctrl     = 1'($urandom);
      @(posedge clk);
      #1;
      check_eq($sformatf("hold%0d_q", i), 32'(q), 32'd10);
      check_eq($sformatf("hold%0d_vld", i), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset between clock edges
    apply("pre_rst", 1'b1, 8'hF9, 8'hC6, 5'd27);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_q", 32'(q), 32'd0);
    check_eq("arst_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    apply("post_rst", 1'b0, 8'h01, 8'h0D, 5'd14);

    // Back-to-back stream: vec i appears after edge i + Lat - 1
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    for (int k = 0; k < int'(NumVec + Lat - 1); k++) begin
      @(negedge clk);
      if (k < int'(NumVec)) begin
        ctrl     = vec_c[k];
        a        = vec_a[k];
        b        = vec_b[k];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k - int'(Lat) + 1 >= 0) begin
        check_eq($sformatf("strm%0d_q", k - int'(Lat) + 1), 32'(q),
                 32'(vec_q[k - int'(Lat) + 1]));
        check_eq($sformatf("strm%0d_vld", k - int'(Lat) + 1), 32'(out_valid), 32'd1);
      end else begin
        check_eq("strm_fill_vld", 32'(out_valid), 32'd0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("drain_vld", 32'(out_valid), 32'd0);
    check_eq("drain_q", 32'(q), 32'(vec_q[NumVec-1]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
